// File: rtl/seg_scan_mux.sv
// Scan controller and digit multiplexer for a bank of common-digit 7-segment displays.
// Each display gets a freeze snapshot, leading-zero suppression and blink; the digit enable is shared.
module seg_scan_mux #(
  parameter int unsigned NUM_DISP    = 2,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_TICKS = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_DISP*(NUM_DIGITS-1)*4-1:0]  value,
  input  logic [NUM_DISP*4-1:0]                 unit_code,
  input  logic [NUM_DISP-1:0]                   freeze,
  input  logic [NUM_DISP-1:0]                   lz_en,
  input  logic [NUM_DISP-1:0]                   blink,
  output logic [NUM_DISP*4-1:0]                 digit_code,
  output logic [NUM_DISP-1:0]                   digit_blank,
  output logic [NUM_DIGITS-1:0]                 digit_en,
  output logic                                  frame_tick
);

  localparam int unsigned NUM_NUM = NUM_DIGITS - 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W   = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]                        presc_q, presc_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [BLK_W-1:0]                        bcnt_q, bcnt_d;
  logic                                    phase_q, phase_d;
  logic [NUM_DISP-1:0][NUM_NUM-1:0][3:0]   snap_q, snap_d;
  logic                                    slot_tick_c, frame_end_c;
  logic [NUM_DISP-1:0]                     nz_c;
  logic [NUM_DIGITS-1:0]                   en_d;
  logic [NUM_DISP*4-1:0]                   code_d;
  logic [NUM_DISP-1:0]                     blank_d;

  // Refresh prescaler, digit index and blink frame counter/phase.
  always_comb begin
    presc_d     = presc_q + PRE_W'(1);
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    slot_tick_c = (presc_q == PRE_W'(REFRESH_DIV - 1));
    frame_end_c = slot_tick_c && (idx_q == LAST_IDX);
    if (slot_tick_c) begin
      presc_d = '0;
      idx_d   = frame_end_c ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_end_c) begin
      if (bcnt_q == BLK_W'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BLK_W'(1);
      end
    end
  end

  // Snapshot follows the live value unless frozen.
  always_comb begin
    snap_d = snap_q;
    for (int unsigned d = 0; d < NUM_DISP; d++) begin
      if (!freeze[d]) begin
        for (int unsigned k = 0; k < NUM_NUM; k++) begin
          snap_d[d][k] = value[(d*NUM_NUM + k)*4 +: 4];
        end
      end
    end
  end

  // A nonzero nibble at or above the current digit keeps it visible under suppression.
  always_comb begin
    nz_c = '0;
    for (int unsigned d = 0; d < NUM_DISP; d++) begin
      for (int unsigned j = 0; j < NUM_NUM; j++) begin
        if ((IDX_W'(j) >= idx_q) && (snap_q[d][j] != 4'h0)) nz_c[d] = 1'b1;
      end
    end
  end

  // Next output values for the current digit slot.
  always_comb begin
    en_d        = '0;
    en_d[idx_q] = 1'b1;
    code_d      = '0;
    blank_d     = '0;
    for (int unsigned d = 0; d < NUM_DISP; d++) begin
      if (idx_q == LAST_IDX) begin
        code_d[d*4 +: 4] = unit_code[d*4 +: 4];
      end else begin
        for (int unsigned k = 0; k < NUM_NUM; k++) begin
          if (idx_q == IDX_W'(k)) code_d[d*4 +: 4] = snap_q[d][k];
        end
      end
      blank_d[d] = (blink[d] && phase_q) ||
                   (lz_en[d] && (idx_q != '0) && (idx_q != LAST_IDX) && !nz_c[d]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      snap_q      <= '0;
      digit_en    <= NUM_DIGITS'(1);
      digit_code  <= '0;
      digit_blank <= '1;
      frame_tick  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      digit_en    <= en_d;
      digit_code  <= code_d;
      digit_blank <= blank_d;
      frame_tick  <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle-count reference model, a digit table and hand-written corner sequences.
module tb_seg_scan_mux;

  localparam int ND = 2;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int B  = 2;

  logic              clk;
  logic              reset_n;
  logic [ND*(N-1)*4-1:0] value;
  logic [ND*4-1:0]   unit_code;
  logic [ND-1:0]     freeze, lz_en, blink;
  logic [ND*4-1:0]   digit_code;
  logic [ND-1:0]     digit_blank;
  logic [N-1:0]      digit_en;
  logic              frame_tick;

  seg_scan_mux #(.NUM_DISP(ND), .NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_TICKS(B)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .unit_code(unit_code),
    .freeze(freeze), .lz_en(lz_en), .blink(blink),
    .digit_code(digit_code), .digit_blank(digit_blank), .digit_en(digit_en),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan derives from the number of clocks since reset.
  int          n;
  int          m_idx, m_ph;
  bit          zero_up;
  logic [3:0]  snap_m [ND][N-1];
  logic [N-1:0]    exp_en;
  logic [ND*4-1:0] exp_code;
  logic [ND-1:0]   exp_blank;
  logic            exp_ft;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0;
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < N-1; k++) snap_m[d][k] = 4'h0;
      exp_en = 4'b0001; exp_code = '0; exp_blank = '1; exp_ft = 1'b0;
    end else begin
      m_idx  = (n / R) % N;
      m_ph   = ((n / (R*N)) / B) % 2;
      exp_en = '0;
      exp_en[m_idx] = 1'b1;
      exp_ft = ((n % (R*N)) == R*N-1);
      for (int d = 0; d < ND; d++) begin
        if (m_idx == N-1) exp_code[d*4 +: 4] = unit_code[d*4 +: 4];
        else              exp_code[d*4 +: 4] = snap_m[d][m_idx];
        zero_up = 1'b1;
        for (int j = m_idx; j < N-1; j++) if (snap_m[d][j] != 4'h0) zero_up = 1'b0;
        exp_blank[d] = (blink[d] && m_ph == 1) ||
                       (lz_en[d] && m_idx >= 1 && m_idx <= N-2 && zero_up);
      end
      for (int d = 0; d < ND; d++)
        if (!freeze[d])
          for (int k = 0; k < N-1; k++) snap_m[d][k] = value[(d*(N-1)+k)*4 +: 4];
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk_on && reset_n) begin
      check("model_en",    32'(digit_en),    32'(exp_en));
      check("model_code",  32'(digit_code),  32'(exp_code));
      check("model_blank", 32'(digit_blank), 32'(exp_blank));
      check("model_ftick", 32'(frame_tick),  32'(exp_ft));
    end
  end

  typedef struct {
    logic [11:0] val;
    logic        lz;
    logic [15:0] codes;
    logic [3:0]  blk;
  } vec_t;

  vec_t tbl [6];

  task automatic wait_digit(input int k);
    int t;
    logic [3:0] e;
    t = 0;
    e = 4'(1 << k);
    while (digit_en !== e && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("wait_digit", 32'(digit_en), 32'(e));
  endtask

  function automatic logic [ND*(N-1)*4-1:0] rand_val();
    logic [ND*(N-1)*4-1:0] v;
    for (int i = 0; i < ND*(N-1); i++)
      v[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    return v;
  endfunction

  initial begin
    int cnt, cnt0, kk;
    tbl[0] = '{12'h123, 1'b0, 16'hA123, 4'b0000};
    tbl[1] = '{12'h005, 1'b1, 16'hA005, 4'b0110};
    tbl[2] = '{12'h000, 1'b1, 16'hA000, 4'b0110};
    tbl[3] = '{12'hFAB, 1'b1, 16'hAFAB, 4'b0000};
    tbl[4] = '{12'h050, 1'b1, 16'hA050, 4'b0100};
    tbl[5] = '{12'h005, 1'b0, 16'hA005, 4'b0000};

    reset_n = 1'b0;
    value = {12'h789, 12'h123};
    unit_code = {4'hC, 4'hA};
    freeze = '0; lz_en = '0; blink = '0;
    repeat (3) @(negedge clk);
    check("rst_en",    32'(digit_en),    32'h1);
    check("rst_code",  32'(digit_code),  32'h0);
    check("rst_blank", 32'(digit_blank), 32'h3);
    check("rst_ftick", 32'(frame_tick),  32'h0);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    // One frame_tick per 16 clocks.
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    check("ftick_count", 32'(cnt), 32'd4);

    // Display 0 digit table.
    for (int t = 0; t < 6; t++) begin
      value = {12'h789, tbl[t].val};
      lz_en = {1'b0, tbl[t].lz};
      repeat (3) @(negedge clk);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        check("tbl_onehot", 32'($onehot(digit_en)), 32'd1);
        kk = 0;
        for (int b = 0; b < N; b++) if (digit_en[b]) kk = b;
        check("tbl_code",  32'(digit_code[3:0]), 32'(tbl[t].codes[kk*4 +: 4]));
        check("tbl_blank", 32'(digit_blank[0]),  32'(tbl[t].blk[kk]));
        check("tbl_code1", 32'(digit_code[7:4]), 32'(((kk == 3) ? 16'hC : (16'h789 >> (kk*4))) & 16'hF));
      end
    end

    // Freeze holds display 0 while its value changes underneath.
    value = {12'h789, 12'h123};
    lz_en = '0;
    repeat (3) @(negedge clk);
    freeze[0] = 1'b1;
    @(negedge clk);
    value = {12'h789, 12'h456};
    repeat (20) @(negedge clk);
    wait_digit(0);
    check("frz_d0",  32'(digit_code[3:0]), 32'h3);
    check("frz_d1",  32'(digit_code[7:4]), 32'h9);
    wait_digit(2);
    check("frz_d2",  32'(digit_code[3:0]), 32'h1);
    freeze[0] = 1'b0;
    repeat (3) @(negedge clk);
    wait_digit(0);
    check("unfrz_d0", 32'(digit_code[3:0]), 32'h6);
    wait_digit(2);
    check("unfrz_d2", 32'(digit_code[3:0]), 32'h4);

    // Blink display 1: half of every 64-clock period blanked; display 0 never.
    blink[1] = 1'b1;
    repeat (2) @(negedge clk);
    cnt = 0; cnt0 = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (digit_blank[1]) cnt++;
      if (digit_blank[0]) cnt0++;
    end
    check("blink_d1", 32'(cnt),  32'd64);
    check("blink_d0", 32'(cnt0), 32'd0);
    blink = '0;

    // Asynchronous reset mid-slot at digit 2, then a full first slot.
    wait_digit(2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_en",    32'(digit_en),    32'h1);
    check("arst_code",  32'(digit_code),  32'h0);
    check("arst_blank", 32'(digit_blank), 32'h3);
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      check("restart_en", 32'(digit_en), (e < 5) ? 32'h1 : 32'h2);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7)  == 0) value     = rand_val();
      if ($urandom_range(0, 31) == 0) freeze    = 2'($urandom);
      if ($urandom_range(0, 31) == 0) lz_en     = 2'($urandom);
      if ($urandom_range(0, 63) == 0) blink     = 2'($urandom);
      if ($urandom_range(0, 63) == 0) unit_code = 8'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
